ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width of the shared RAM.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, address width of the shared RAM.
REQ-003 The block SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports req0/req1  input  1  access request, requester 0/1.
REQ-006 The block SHALL have ports we0/we1  input  1  1 = write, 0 = read, qualified by reqN.
REQ-007 The block SHALL have ports lock0/lock1  input  1  keep ownership after this access (burst).
REQ-008 The block SHALL have ports addr0/addr1  input  ADDR_WIDTH  access address.
REQ-009 The block SHALL have ports wdata0/wdata1  input  DATA_WIDTH  write data.
REQ-010 The block SHALL have ports gnt0/gnt1  output  1  access accepted this cycle (combinational).
REQ-011 The block SHALL have ports rvalid0/rvalid1  output  1  read data valid, registered.
REQ-012 The block SHALL have ports rdata0/rdata1  output  DATA_WIDTH  read data, meaningful only when rvalidN=1.
REQ-013 The block SHALL have port ram_addr  output  ADDR_WIDTH  address to the single-port RAM.
REQ-014 The block SHALL have port ram_data  output  DATA_WIDTH  write data to the RAM.
REQ-015 The block SHALL have port ram_we  output  1  RAM write enable.
REQ-016 The block SHALL have port ram_q  input  DATA_WIDTH  RAM read data, valid 1 cycle after the address edge.

Function
REQ-017 At most one of gnt0/gnt1 SHALL be 1 in any cycle; gntN=1 only when reqN=1.
REQ-018 When gntN=1, ram_addr=addrN, ram_data=wdataN, ram_we=weN in the same cycle; with no grant, ram_we=0 and ram_addr/ram_data hold their previous values.
REQ-019 The FSM SHALL have states IDLE, LOCK0, LOCK1.
REQ-020 In IDLE with one request, that requester SHALL be granted; with both, the requester not granted most recently (last pointer) SHALL be granted.
REQ-021 In IDLE, a grant to N with lockN=1 SHALL move to LOCKN; with lockN=0, the FSM SHALL stay in IDLE.
REQ-022 In LOCKN, only requester N SHALL be granted; the other requester's request SHALL wait.
REQ-023 In LOCKN, a grant with lockN=0 or a cycle with reqN=0 SHALL return to IDLE.
REQ-024 The last pointer SHALL update to N on every grant to N.
REQ-025 A granted read (weN=0) SHALL produce rvalidN=1 for exactly one cycle, on the cycle after the grant, with rdataN=ram_q.
REQ-026 A granted write SHALL produce no rvalid pulse.
REQ-027 Back-to-back grants SHALL be sustained, one access per cycle with no bubbles.
REQ-028 A read granted on the cycle after a write to the same address SHALL return the newly written data.
REQ-029 When the FSM is in IDLE and both requesters hold req continuously, grants SHALL alternate 0,1,0,1,...

Reset
REQ-030 While rst=1: state=IDLE, last pointer=1 (requester 0 wins the first tie), rvalid0=rvalid1=0, ram_we=0, gnt0=gnt1=0.
REQ-031 While rst=1: ram_addr=0, ram_data=0, rdata0=rdata1=0.
REQ-032 A read in flight when rst asserts SHALL be discarded; rvalid SHALL not pulse for it after release.

Verification
REQ-033 Reset release, req0=req1=1, both reads, lock=0 for 4 cycles -> gnt sequence 0,1,0,1; rvalid0/rvalid1 alternate one cycle later.
REQ-034 Requester 0 writes 8'hA5 to addr 8'h10, then requester 1 reads 8'h10 the next cycle -> rvalid1=1 with rdata1=8'hA5.
REQ-035 Requester 1 issues a 3-read burst (lock1=1,1,0) while req0=1 throughout -> gnt1 for 3 consecutive cycles, then gnt0.
REQ-036 In LOCK0, req0 drops for one cycle -> FSM returns to IDLE and a pending req1 is granted on that cycle.
REQ-037 rst asserted in the cycle after a read grant -> no rvalid pulse, and all outputs are at reset values asynchronously.
REQ-038 Random req/we/lock stimulus for 10k cycles -> never both gnt=1; ram_we=0 whenever no grant; each read yields exactly one matching rvalid.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Round-robin on ties, lockable bursts, one access per cycle, registered read-valid.
module ram_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic                  lock0,
   input  logic                  lock1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t                  state, next_state;
   logic                    last;      // requester granted most recently
   logic [ADDR_WIDTH-1:0]   addr_hold;
   logic [DATA_WIDTH-1:0]   data_hold;

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      next_state = IDLE;
      if (!rst) begin
         // A lock only excludes the other side while the owner keeps requesting;
         // once the owner drops req the cycle is arbitrated as if idle.
         if (state == LOCK0 && req0) begin
            gnt0 = 1'b1;
         end else if (state == LOCK1 && req1) begin
            gnt1 = 1'b1;
         end else if (req0 && req1) begin
            gnt0 = last;
            gnt1 = ~last;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
         if (gnt0 && lock0) begin
            next_state = LOCK0;
         end else if (gnt1 && lock1) begin
            next_state = LOCK1;
         end
      end
   end

   // With no grant the RAM bus keeps its last address/data; reset clears the hold registers.
   always_comb begin
      ram_addr = addr_hold;
      ram_data = data_hold;
      ram_we   = 1'b0;
      if (gnt0) begin
         ram_addr = addr0;
         ram_data = wdata0;
         ram_we   = we0;
      end else if (gnt1) begin
         ram_addr = addr1;
         ram_data = wdata1;
         ram_we   = we1;
      end
   end

   // NOTE: state is written with non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         addr_hold <= '0;
         data_hold <= '0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
      end else begin
         state     <= next_state;
         addr_hold <= ram_addr;
         data_hold <= ram_data;
         rvalid0   <= gnt0 & ~we0;
         rvalid1   <= gnt1 & ~we1;
         if (gnt0) begin
            last <= 1'b0;
         end else if (gnt1) begin
            last <= 1'b1;
         end
      end
   end

   // ram_q is the RAM's registered output, so it lines up with the rvalid pulse.
   assign rdata0 = rvalid0 ? ram_q : '0;
   assign rdata1 = rvalid1 ? ram_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a RAM stand-in, a reference arbitration model,
// directed scenarios and a long random run.
module tb_ram_arbiter;

   localparam int DW = 8;
   localparam int AW = 8;

   typedef struct {
      bit            req;
      bit            we;
      bit            lock;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } port_t;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic          lock0 = 1'b0, lock1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
   logic [DW-1:0] rdata0, rdata1, ram_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_q = '0;

   ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM stand-in.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_data;
      ram_q <= ram[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: who may be granted, what the RAM holds, which reads are owed.
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            m_last, m_locked;
   logic [AW-1:0] m_hold_addr;
   logic [DW-1:0] m_hold_data;
   exp_t          q0[$], q1[$];

   task automatic model_reset();
      m_last      = 1;
      m_locked    = -1;
      m_hold_addr = '0;
      m_hold_data = '0;
      q0.delete();
      q1.delete();
   endtask

   function automatic int model_grant(input bit r0, input bit r1);
      if (m_locked == 0 && r0) return 0;
      if (m_locked == 1 && r1) return 1;
      if (r0 && r1) return (m_last == 0) ? 1 : 0;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   // One bus cycle: drive, check the combinational grant/RAM bus, update the model.
   task automatic cycle(input port_t a, input port_t b, output int g);
      int    eg;
      port_t s;
      @(posedge clk);
      #1;
      req0 = a.req; we0 = a.we; lock0 = a.lock; addr0 = a.addr; wdata0 = a.data;
      req1 = b.req; we1 = b.we; lock1 = b.lock; addr1 = b.addr; wdata1 = b.data;
      #1;
      eg = model_grant(a.req, b.req);
      check("gnt", {gnt1, gnt0}, (eg == 0) ? 2'b01 : (eg == 1) ? 2'b10 : 2'b00);
      if (eg >= 0) begin
         s = (eg == 0) ? a : b;
         check("ram_we", ram_we, s.we);
         check("ram_addr", ram_addr, s.addr);
         check("ram_data", ram_data, s.data);
         if (s.we) begin
            ref_mem[s.addr] = s.data;
         end else if (eg == 0) begin
            q0.push_back('{ref_mem[s.addr], cyc + 1});
         end else begin
            q1.push_back('{ref_mem[s.addr], cyc + 1});
         end
         m_hold_addr = s.addr;
         m_hold_data = s.data;
         m_last      = eg;
         m_locked    = s.lock ? eg : -1;
      end else begin
         check("ram_we_idle", ram_we, 1'b0);
         check("ram_addr_hold", ram_addr, m_hold_addr);
         check("ram_data_hold", ram_data, m_hold_data);
         m_locked = -1;
      end
      g = gnt0 ? 0 : (gnt1 ? 1 : -1);
   endtask

   // Monitor: every owed read must show up exactly on its due cycle, and nothing else.
   always @(negedge clk) begin
      bit   e0, e1;
      exp_t h;
      e0 = (q0.size() > 0) && (q0[0].due == cyc);
      e1 = (q1.size() > 0) && (q1[0].due == cyc);
      check("rvalid0", rvalid0, e0);
      check("rvalid1", rvalid1, e1);
      if (e0) begin
         h = q0.pop_front();
         check("rdata0", rdata0, h.data);
      end
      if (e1) begin
         h = q1.pop_front();
         check("rdata1", rdata1, h.data);
      end
   end

   function automatic port_t rd(input logic [AW-1:0] ad, input bit lk);
      return '{1'b1, 1'b0, lk, ad, 8'h00};
   endfunction

   function automatic port_t wr(input logic [AW-1:0] ad, input logic [DW-1:0] d);
      return '{1'b1, 1'b1, 1'b0, ad, d};
   endfunction

   function automatic port_t none();
      return '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
   endfunction

   function automatic port_t rnd();
      port_t p;
      p.req  = ($urandom_range(0, 3) != 0);
      p.we   = $urandom_range(0, 1);
      p.lock = ($urandom_range(0, 9) < 3);
      p.addr = AW'($urandom_range(0, 15));
      p.data = DW'($urandom);
      return p;
   endfunction

   initial begin
      int g, prev;
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i]     = DW'(i * 7 + 3);
         ref_mem[i] = DW'(i * 7 + 3);
      end
      model_reset();

      // Reset: requests present but nothing may be granted or driven.
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 8'h5C; wdata0 = 8'h77;
      repeat (2) @(negedge clk);
      check("rst_gnt", {gnt1, gnt0}, 2'b00);
      check("rst_ram_we", ram_we, 1'b0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_data", ram_data, 0);
      check("rst_rdata", {rdata1, rdata0}, 0);
      @(posedge clk);
      #1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0;
      rst = 1'b0;

      // Both reading continuously from idle: strict alternation starting with 0.
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         cycle(rd(8'(i), 1'b0), rd(8'(8'h20 + i), 1'b0), g);
         check("alt_seq", g, i % 2);
         if (i > 0) check("alt_rvalid", {rvalid1, rvalid0}, (prev == 0) ? 2'b01 : 2'b10);
         prev = g;
      end

      // Write then read-back of the same address by the other requester.
      cycle(wr(8'h10, 8'hA5), none(), g);
      cycle(none(), rd(8'h10, 1'b0), g);
      check("raw_gnt", g, 1);
      cycle(none(), none(), g);
      check("raw_rvalid1", rvalid1, 1'b1);
      check("raw_rdata1", rdata1, 8'hA5);

      // Locked burst of three reads by requester 1 while requester 0 waits.
      cycle(rd(8'h01, 1'b0), none(), g);
      cycle(rd(8'h02, 1'b0), rd(8'h30, 1'b1), g);
      check("burst_1", g, 1);
      cycle(rd(8'h02, 1'b0), rd(8'h31, 1'b1), g);
      check("burst_2", g, 1);
      cycle(rd(8'h02, 1'b0), rd(8'h32, 1'b0), g);
      check("burst_3", g, 1);
      cycle(rd(8'h02, 1'b0), rd(8'h33, 1'b0), g);
      check("burst_after", g, 0);

      // Owner of LOCK0 drops req for a cycle: requester 1 gets in immediately.
      cycle(rd(8'h04, 1'b1), none(), g);
      cycle(none(), rd(8'h05, 1'b0), g);
      check("lock_drop", g, 1);

      // Reset during a read in flight (and with a previous read's rvalid high).
      cycle(none(), rd(8'h40, 1'b0), g);
      cycle(rd(8'h33, 1'b0), none(), g);
      check("inflight_gnt", g, 0);
      #1;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      #1;
      check("arst_rvalid", {rvalid1, rvalid0}, 2'b00);
      check("arst_gnt", {gnt1, gnt0}, 2'b00);
      check("arst_ram_addr", ram_addr, 0);
      check("arst_rdata", {rdata1, rdata0}, 0);
      repeat (2) @(posedge clk);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      rst = 1'b0;
      model_reset();

      // Long random run against the reference model.
      for (int i = 0; i < 10000; i++) begin
         cycle(rnd(), rnd(), g);
         if (gnt0 && gnt1) check("both_gnt", 1'b1, 1'b0);
      end
      cycle(none(), none(), g);
      cycle(none(), none(), g);
      cycle(none(), none(), g);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
